// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter: shares one data-memory port between the CPU M-stage port (C)
// and a debug/DMA loader port (D).
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   c_req/c_addr/c_wdata/c_byteen   CPU request (byteen==0 means read)
//   c_gnt                CPU access accepted this cycle (combinational)
//   c_rvalid/c_rdata     CPU read response, one cycle after the granted read
//   d_*                  same set of ports for the debug/DMA requester
//   m_addr/m_wdata/m_byteen/m_re    memory request (word-aligned address)
//   m_rdata              memory read data, valid the cycle after m_re
//   conflict_cnt         saturating count of cycles with both requesting
module dm_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            c_req,
  input  logic [AW-1:0]   c_addr,
  input  logic [DW-1:0]   c_wdata,
  input  logic [DW/8-1:0] c_byteen,
  output logic            c_gnt,
  output logic            c_rvalid,
  output logic [DW-1:0]   c_rdata,
  input  logic            d_req,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_byteen,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_byteen,
  output logic            m_re,
  input  logic [DW-1:0]   m_rdata,
  output logic [CW-1:0]   conflict_cnt
);

  localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  logic          r_last_win;  // 0 = C won last, 1 = D won last
  logic          r_rd_pend;
  logic          r_rd_own;    // 0 = C, 1 = D
  logic [CW-1:0] r_conflict_cnt;

  logic w_both;
  logic w_win_c;
  logic w_win_d;
  logic w_rd;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Arbitration and winner drive, all combinational; everything is held low
  // while reset is asserted so nothing reaches memory during reset.
  always_comb begin
    w_both   = c_req & d_req;
    // On conflict the requester that did not win last time gets the port.
    w_win_c  = reset & c_req & (~d_req | r_last_win);
    w_win_d  = reset & d_req & (~c_req | ~r_last_win);
    m_addr   = '0;
    m_wdata  = '0;
    m_byteen = '0;
    m_re     = 1'b0;
    if (w_win_c) begin
      m_addr   = c_addr & WORD_MASK;
      m_wdata  = c_wdata;
      m_byteen = c_byteen;
      m_re     = (c_byteen == '0);
    end else if (w_win_d) begin
      m_addr   = d_addr & WORD_MASK;
      m_wdata  = d_wdata;
      m_byteen = d_byteen;
      m_re     = (d_byteen == '0);
    end
    w_rd     = m_re;
  end

  // State: round-robin pointer, outstanding-read tracking, conflict counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_win     <= 1'b1;
      r_rd_pend      <= 1'b0;
      r_rd_own       <= 1'b0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_win_c | w_win_d) r_last_win <= w_win_d;
      r_rd_pend <= w_rd;
      if (w_rd) r_rd_own <= w_win_d;
      if (w_both) r_conflict_cnt <= sat_inc(r_conflict_cnt);
    end
  end

  // Response routing: read data goes only to the port that issued the read
  always_comb begin
    c_gnt        = w_win_c;
    d_gnt        = w_win_d;
    c_rvalid     = r_rd_pend & ~r_rd_own;
    d_rvalid     = r_rd_pend & r_rd_own;
    c_rdata      = c_rvalid ? m_rdata : '0;
    d_rdata      = d_rvalid ? m_rdata : '0;
    conflict_cnt = r_conflict_cnt;
  end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
module tb_dm_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, d_req;
  logic [31:0] c_addr, d_addr, c_wdata, d_wdata;
  logic [3:0]  c_byteen, d_byteen;
  logic        c_gnt, d_gnt, c_rvalid, d_rvalid, m_re;
  logic [31:0] c_rdata, d_rdata, m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic [3:0]  m_byteen;
  logic [15:0] conflict_cnt;

  int errors = 0;
  int checks = 0;

  // Expected read responses: {owner, data}
  logic [32:0] rsp_q[$];
  logic        exp_last;
  logic [15:0] exp_cnt;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  dm_bus_arbiter #(.AW(32), .DW(32), .CW(16)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_byteen(c_byteen),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_byteen(d_byteen),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_byteen(m_byteen), .m_re(m_re),
    .m_rdata(m_rdata), .conflict_cnt(conflict_cnt)
  );

  // Simple synchronous memory with one-cycle read latency
  always @(posedge clk) begin
    if (m_re) m_rdata <= mem[m_addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (m_byteen[b]) mem[m_addr[7:2]][8*b +: 8] <= m_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rsp_q.delete();
    exp_last = 1'b1;
    exp_cnt  = '0;
  endtask

  // One cycle: drive inputs (just after posedge), check at negedge, advance.
  task automatic step(input logic cr, input logic [31:0] ca, input logic [3:0] cb,
                      input logic [31:0] cw, input logic dr, input logic [31:0] da,
                      input logic [3:0] db, input logic [31:0] dw);
    logic        wc, wd;
    logic [32:0] e;
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    c_req = cr; c_addr = ca; c_byteen = cb; c_wdata = cw;
    d_req = dr; d_addr = da; d_byteen = db; d_wdata = dw;
    @(negedge clk);
    if (rsp_q.size() > 0) begin
      e = rsp_q.pop_front();
      chk("c_rvalid", {31'b0, c_rvalid}, {31'b0, ~e[32]});
      chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, e[32]});
      chk("c_rdata", c_rdata, e[32] ? 32'h0 : e[31:0]);
      chk("d_rdata", d_rdata, e[32] ? e[31:0] : 32'h0);
    end else begin
      chk("rvalid_idle", {30'b0, c_rvalid, d_rvalid}, 32'h0);
    end
    wc = cr & (~dr | exp_last);
    wd = dr & (~cr | ~exp_last);
    ea = wc ? (ca & 32'hFFFF_FFFC) : wd ? (da & 32'hFFFF_FFFC) : 32'h0;
    eb = wc ? cb : wd ? db : 4'h0;
    ew = wc ? cw : wd ? dw : 32'h0;
    chk("gnt", {30'b0, c_gnt, d_gnt}, {30'b0, wc, wd});
    chk("m_addr", m_addr, ea);
    chk("m_byteen", {28'b0, m_byteen}, {28'b0, eb});
    chk("m_wdata", m_wdata, ew);
    chk("m_re", {31'b0, m_re}, {31'b0, (wc | wd) & (eb == 4'h0)});
    chk("conflict_cnt", {16'b0, conflict_cnt}, {16'b0, exp_cnt});
    if ((wc | wd) && eb == 4'h0) rsp_q.push_back({wd, mem[ea[7:2]]});
    if (wc | wd) exp_last = wd;
    if (cr & dr && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 + i;
    mem[4] = 32'h1234_5678;
    mem[8] = 32'hCAFE_F00D;
    model_reset();

    // Reset state with both requesting: nothing may reach memory
    reset = 1'b0;
    c_req = 1; c_addr = 32'h10; c_byteen = 0; c_wdata = 0;
    d_req = 1; d_addr = 32'h20; d_byteen = 0; d_wdata = 0;
    @(negedge clk);
    chk("rst_gnt", {30'b0, c_gnt, d_gnt}, 32'h0);
    chk("rst_m", {m_addr[29:0], m_re, |m_byteen}, 32'h0);
    chk("rst_rv", {30'b0, c_rvalid, d_rvalid}, 32'h0);
    chk("rst_data", c_rdata | d_rdata | m_wdata, 32'h0);
    chk("rst_cnt", {16'b0, conflict_cnt}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Half-word write to 0x6: aligned address, no response afterwards
    step(1, 32'h6, 4'b1100, 32'hABCD_0000, 0, 0, 0, 0);
    idle();
    // C read of word 4
    step(1, 32'h10, 4'b0000, 0, 0, 0, 0, 0);
    idle();

    // Continuous conflict from reset: C,D,C,D then count of 4
    reset = 1'b0; #1; model_reset(); @(posedge clk); #1; reset = 1'b1;
    repeat (4) step(1, 32'h10, 0, 0, 1, 32'h20, 0, 0);
    idle();

    // Back-to-back reads from different owners
    step(1, 32'h10, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h20, 0, 0);
    idle();

    // D read, then reset pulse before data returns: the read is dropped
    step(0, 0, 0, 0, 1, 32'h20, 0, 0);
    reset = 1'b0;
    c_req = 0; d_req = 0;
    #1;
    chk("pulse_drop", {30'b0, c_rvalid, d_rvalid}, 32'h0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    step(1, 32'h10, 4'hF, 32'h1111_2222, 1, 32'h20, 4'hF, 32'h3333_4444);
    idle();

    // Counter saturation
    reset = 1'b0; #1; model_reset(); @(posedge clk); #1; reset = 1'b1;
    repeat (16'hFFFE) step(1, 32'h0, 4'hF, 32'h0, 1, 32'h4, 4'hF, 32'h0);
    repeat (3) step(1, 32'h0, 4'hF, 32'h0, 1, 32'h4, 4'hF, 32'h0);
    idle();
    chk("cnt_sat", {16'b0, conflict_cnt}, 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_bus_arbiter.md
Name: dm_bus_arbiter

Overview:
- Shares the single data-memory port of the P6 CPU between two requesters: the CPU M-stage data port (C) and a debug/DMA loader port (D).
- Arbitrates between them each cycle, forwards the winner's word-aligned access with its byte enables to memory, and routes the one-cycle-late read data back to the requester that issued the read.
- Sits between the CPU top level and the data memory in the testbench/system wrapper.

Parameters:
- AW, 32, address width.
- DW, 32, data width (byte enables are DW/8 = 4 bits).
- CW, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- c_req  in  1  CPU access request.
- c_addr  in  AW  CPU byte address.
- c_wdata  in  DW  CPU write data, already byte-lane positioned.
- c_byteen  in  4  CPU byte enables; 4'b0000 with c_req means read.
- c_gnt  out  1  CPU access accepted this cycle; CPU must stall while c_req=1 and c_gnt=0.
- c_rvalid  out  1  CPU read data valid.
- c_rdata  out  DW  CPU read data.
- d_req, d_addr, d_wdata, d_byteen, d_gnt, d_rvalid, d_rdata  same widths, directions and meanings as the c_* ports, for requester D.
- m_addr  out  AW  memory word address (request address & ~3).
- m_wdata  out  DW  memory write data.
- m_byteen  out  4  memory byte write enables.
- m_re  out  1  memory read strobe.
- m_rdata  in  DW  memory read data, valid the cycle after m_re.
- conflict_cnt  out  CW  number of cycles in which both requesters were requesting.

Behaviour:
- Registers:
  - last_win: 0 = C, 1 = D.
  - rd_pend: 1 bit.
  - rd_own: 0 = C, 1 = D.
  - conflict_cnt.
- Reset (reset=0, asynchronous):
  - last_win=1, so C wins the first conflict.
  - rd_pend=0, rd_own=0, conflict_cnt=0.
  - c_gnt, d_gnt, m_re, m_byteen, c_rvalid, d_rvalid forced to 0.
  - m_addr, m_wdata, c_rdata, d_rdata forced to 0.
- Arbitration is combinational in the same cycle:
  - Only c_req: grant C.
  - Only d_req: grant D.
  - Both requesting: grant the requester that is not last_win (round-robin).
  - Neither: no grant.
- At most one gnt is high per cycle. A requester loses at most one consecutive cycle while the other keeps requesting.
- Winner drive:
  - m_addr = addr & ~3, m_wdata = wdata, m_byteen = byteen.
  - m_re = (byteen == 0).
  - With no winner: m_addr=0, m_wdata=0, m_byteen=0, m_re=0.
- Writes complete in the grant cycle; no response is returned for writes.
- Read latency is exactly 1 cycle:
  - On a granted read: rd_pend<=1 and rd_own<=winner.
  - In the following cycle: x_rvalid=1 and x_rdata=m_rdata for x = rd_own. The other port sees rvalid=0 and rdata=0.
  - With no read granted: rd_pend<=0.
- Pipelining: a new access (read or write) may be granted in the same cycle a previous read's data returns. Back-to-back reads therefore sustain 1 per cycle.
- last_win updates on every grant; it holds when there is no grant.
- conflict_cnt increments each cycle with c_req & d_req and saturates at all-ones.
- Requests are sampled each cycle; there is no internal queueing. A requester that is not granted must hold its request stable until granted.
- Reset asserted mid-read: the pending read is dropped and no rvalid is produced after release.
- The byte-enable pattern (1, 2 or 4 lanes) is forwarded unchanged. Alignment checking is the requester's job.

Test Plan:
- Reset release, c_req=1, c_addr=0x0000_0006, c_byteen=4'b1100, c_wdata=0xABCD_0000 -> same cycle: c_gnt=1, m_addr=0x4, m_byteen=4'b1100, m_re=0; no rvalid the next cycle.
- C reads 0x10 while memory word 4 = 0x1234_5678 -> c_gnt=1 and m_re=1 in cycle t; c_rvalid=1, c_rdata=0x1234_5678, d_rvalid=0 in cycle t+1.
- C and D both request continuously for 4 cycles from reset -> grants C,D,C,D; conflict_cnt=4; each gnt is high in alternate cycles only.
- C read granted at t, D read of 0x20 granted at t+1 -> c_rvalid at t+1 and d_rvalid at t+2, each carrying its own word; no cross-routing.
- D read granted, then reset=0 pulsed for one cycle before the data cycle -> d_rvalid stays 0; after release, the first conflict goes to C.
- Force conflict_cnt to 0xFFFE, then apply 3 conflict cycles -> counter reads 0xFFFF and holds.
